// File: rtl/ultrasonic_pkg.sv
// Shared constants, state encoding and helpers for the HC-SR04 echo path.
package ultrasonic_pkg;

    localparam int unsigned CLK_FREQ_HZ   = 50000000;
    localparam int unsigned TRIG_CYCLES   = 500;        // 10 us trigger pulse at 50 MHz
    localparam int unsigned CYCLES_PER_CM = 2900;       // 58 us round trip per cm
    localparam int unsigned MAX_CM        = 400;
    localparam int unsigned RISE_TIMEOUT  = 1500000;    // 30 ms
    localparam int unsigned FALL_TIMEOUT  = 1500000;
    localparam int unsigned CM_WIDTH      = 9;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRise,
        StMeasure,
        StWaitFall,
        StDone
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_echo_meter_if.sv
// Control/result bundle between the echo meter and its consumer.
interface ultrasonic_echo_meter_if #(
    parameter int unsigned CM_WIDTH = ultrasonic_pkg::CM_WIDTH
);
    logic                start;
    logic                echo;
    logic [CM_WIDTH-1:0] distance_cm;
    logic                valid;
    logic                timeout;
    logic                out_of_range;
    logic                busy;

    // Consumer side: arms measurements, supplies the raw echo, reads results.
    modport master (
        output start,
        output echo,
        input  distance_cm,
        input  valid,
        input  timeout,
        input  out_of_range,
        input  busy
    );

    // Meter side.
    modport slave (
        input  start,
        input  echo,
        output distance_cm,
        output valid,
        output timeout,
        output out_of_range,
        output busy
    );
endinterface

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous level plus registered edge detect.
// Input change to rise/fall pulse is three clk edges.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, prev_q, rise_q, fall_q;

    // Synchronize, keep one older sample, and register single-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= async_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
            fall_q <= ~s2_q & prev_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ultrasonic_echo_meter.sv
// Measures the HC-SR04 echo width after each start and reports whole centimetres.
// Division is avoided: a prescaler counts CYCLES_PER_CM clocks per centimetre step.
module ultrasonic_echo_meter #(
    parameter int unsigned CYCLES_PER_CM = ultrasonic_pkg::CYCLES_PER_CM,
    parameter int unsigned MAX_CM        = ultrasonic_pkg::MAX_CM,
    parameter int unsigned RISE_TIMEOUT  = ultrasonic_pkg::RISE_TIMEOUT,
    parameter int unsigned FALL_TIMEOUT  = ultrasonic_pkg::FALL_TIMEOUT,
    parameter int unsigned CM_WIDTH      = ultrasonic_pkg::CM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    ultrasonic_echo_meter_if.slave  bus
);

    import ultrasonic_pkg::*;

    localparam int unsigned PRESC_W = $clog2(CYCLES_PER_CM + 1);
    localparam int unsigned TIMER_W = $clog2(max_u(RISE_TIMEOUT, FALL_TIMEOUT) + 1);

    localparam logic [PRESC_W-1:0]  PRESC_FULL = PRESC_W'(CYCLES_PER_CM);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
    localparam logic [CM_WIDTH-1:0] CM_MAX     = CM_WIDTH'(MAX_CM);
    localparam logic [TIMER_W-1:0]  RISE_LAST  = TIMER_W'(RISE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0]  FALL_LAST  = TIMER_W'(FALL_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [CM_WIDTH-1:0]  cm_q, cm_d;
    logic [CM_WIDTH-1:0]  result_q, result_d;
    logic                 sat_q, sat_d;
    logic [CM_WIDTH-1:0]  distance_q, distance_d;
    logic                 oor_q, oor_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;

    logic                 rise, fall;
    logic                 cm_inc;
    logic [CM_WIDTH-1:0]  cm_next;

    echo_sync u_echo_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.echo),
        .rise     (rise),
        .fall     (fall)
    );

    // State, counters and output registers; reset discards any partial measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            timer_q    <= '0;
            cm_q       <= '0;
            result_q   <= '0;
            sat_q      <= 1'b0;
            distance_q <= '0;
            oor_q      <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            cm_q       <= cm_d;
            result_q   <= result_d;
            sat_q      <= sat_d;
            distance_q <= distance_d;
            oor_q      <= oor_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic for the measurement sequencer.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        timer_d    = timer_q;
        cm_d       = cm_q;
        result_d   = result_q;
        sat_d      = sat_q;
        distance_d = distance_q;
        oor_d      = oor_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;

        // presc_q == CYCLES_PER_CM means a full centimetre has accumulated, so the
        // count including this cycle is cm_q + 1 whole cm (floor of cycles / CPC).
        cm_inc  = (presc_q == PRESC_FULL);
        cm_next = cm_q + CM_WIDTH'(cm_inc);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    timer_d = '0;
                    state_d = StWaitRise;
                end
            end
            StWaitRise: begin
                // Only a synchronized 0->1 edge counts, so an echo already high at
                // arm time is ignored until it drops and rises again.
                if (rise) begin
                    presc_d = PRESC_ONE;
                    cm_d    = '0;
                    sat_d   = 1'b0;
                    state_d = StMeasure;
                end else if (timer_q == RISE_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StMeasure: begin
                if (fall) begin
                    // Fall wins over saturation landing on the same cycle.
                    result_d = cm_next;
                    sat_d    = (cm_next == CM_MAX);
                    state_d  = StDone;
                end else begin
                    presc_d = cm_inc ? PRESC_ONE : presc_q + PRESC_W'(1);
                    cm_d    = cm_next;
                    if (cm_next == CM_MAX) begin
                        result_d = CM_MAX;
                        sat_d    = 1'b1;
                        timer_d  = '0;
                        state_d  = StWaitFall;
                    end
                end
            end
            StWaitFall: begin
                if (fall) begin
                    state_d = StDone;
                end else if (timer_q == FALL_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StDone: begin
                distance_d = result_q;
                oor_d      = sat_q;
                valid_d    = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come straight from registers; busy is a decode of the state register.
    always_comb begin
        bus.distance_cm  = distance_q;
        bus.out_of_range = oor_q;
        bus.valid        = valid_q;
        bus.timeout      = timeout_q;
        bus.busy         = (state_q != StIdle);
    end

endmodule
